// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic prio;
  logic owner;
  logic grant;
  logic accept0;
  logic accept1;
  logic accept;

  // Pick the port to serve: a lone valid wins outright, a tie goes to the priority pointer
  always_comb begin
    grant = prio;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  // Ready only in IDLE, only for the granted port, and never while reset is held
  assign req0_ready = !reset && (state == IDLE) && (grant == 1'b0);
  assign req1_ready = !reset && (state == IDLE) && (grant == 1'b1);

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;

  assign rsp_valid = (state == RESP);

  // Next-state logic: one op in flight, EXEC lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight op without producing a response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration pointer and owner tag: prio moves to the other port on every accept
  always_ff @(posedge clk) begin
    if (reset) begin
      prio  <= 1'b0;
      owner <= 1'b0;
    end else if (accept) begin
      prio  <= ~accept1;
      owner <= accept1;
    end
  end

  // ALU operand registers, loaded from the accepted port and held through EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else if (accept1) begin
      alu_a       <= req1_a;
      alu_b       <= req1_b;
      alu_control <= req1_op;
    end else if (accept0) begin
      alu_a       <= req0_a;
      alu_b       <= req0_b;
      alu_control <= req0_op;
    end
  end

  // Response capture at the end of EXEC; held unchanged while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= owner;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  logic             clk;
  logic             reset;
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  logic prio_m;
  int   errors = 0;
  int   checks = 0;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [OPW-1:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b111:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    prio_m = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle with inputs already driven
  task automatic txn(input int stall, input string tag);
    logic             g;
    exp_t             e;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [OPW-1:0]   eop;
    #1;
    if (req0_valid && req1_valid) g = prio_m;
    else g = req1_valid;
    chkb({tag, " req0_ready"}, req0_ready, !g);
    chkb({tag, " req1_ready"}, req1_ready, g);
    ea  = g ? req1_a : req0_a;
    eb  = g ? req1_b : req0_b;
    eop = g ? req1_op : req0_op;
    e.id   = g;
    e.res  = alu_fn(ea, eb, eop);
    e.zero = (e.res == '0);
    sb.push_back(e);
    prio_m = !g;
    @(negedge clk);
    chkb({tag, " exec rsp_valid"}, rsp_valid, 1'b0);
    chkb({tag, " exec readys"}, req0_ready | req1_ready, 1'b0);
    chk({tag, " exec alu_a"}, alu_a, ea);
    chk({tag, " exec alu_b"}, alu_b, eb);
    chk({tag, " exec alu_control"}, {{(WIDTH-OPW){1'b0}}, alu_control}, {{(WIDTH-OPW){1'b0}}, eop});
    rsp_ready = (stall == 0);
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chkb({tag, " hold rsp_valid"}, rsp_valid, 1'b1);
      chkb({tag, " hold rsp_id"}, rsp_id, sb[0].id);
      chk({tag, " hold rsp_result"}, rsp_result, sb[0].res);
      chkb({tag, " hold readys"}, req0_ready | req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    chkb({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chkb({tag, " rsp_id"}, rsp_id, e.id);
    chk({tag, " rsp_result"}, rsp_result, e.res);
    chkb({tag, " rsp_zero"}, rsp_zero, e.zero);
    @(negedge clk);
    chkb({tag, " idle rsp_valid"}, rsp_valid, 1'b0);
  endtask

  // Accept an op, then reset in EXEC (at_resp=0) or RESP (at_resp=1); no response may appear
  task automatic abort(input bit at_resp, input string tag);
    logic g;
    #1;
    if (req0_valid && req1_valid) g = prio_m;
    else g = req1_valid;
    chkb({tag, " accept ready0"}, req0_ready, !g);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (at_resp) begin
      @(negedge clk);
      chkb({tag, " resp rsp_valid"}, rsp_valid, 1'b1);
    end
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chkb({tag, " rst rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rst alu_a"}, alu_a, '0);
    reset     = 1'b0;
    prio_m    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chkb({tag, " after rsp_valid"}, rsp_valid, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    prio_m    = 1'b0;
    repeat (2) @(negedge clk);
    chkb("reset req0_ready", req0_ready, 1'b0);
    chkb("reset req1_ready", req1_ready, 1'b0);
    chkb("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_result", rsp_result, '0);
    chkb("reset rsp_zero", rsp_zero, 1'b0);
    chkb("reset rsp_id", rsp_id, 1'b0);
    chk("reset alu_a", alu_a, '0);
    chk("reset alu_b", alu_b, '0);
    chk("reset alu_control", {{(WIDTH-OPW){1'b0}}, alu_control}, '0);
    req0_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);

    // 1: single add on port 0
    req0_a = 5; req0_b = 3; req0_op = 3'b000; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    txn(0, "t1");
    req0_valid = 1'b0;
    pulse_reset();

    // 2: both ports continuously valid, grants alternate starting at port 0
    req0_a = 10;    req0_b = 10;    req0_op = 3'b001; req0_valid = 1'b1;
    req1_a = 'hF0;  req1_b = 'h3C;  req1_op = 3'b111; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) txn(0, $sformatf("t2[%0d]", i));
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 3: back-pressure on a port 1 slt
    req1_a = 2; req1_b = 7; req1_op = 3'b101; req1_valid = 1'b1;
    txn(5, "t3");
    req1_valid = 1'b0;

    // 4: lone port 1 grant moves priority to port 0
    req1_a = 'h0F; req1_b = 'hF0; req1_op = 3'b011; req1_valid = 1'b1;
    txn(0, "t4a");
    req0_a = 7; req0_b = 2; req0_op = 3'b001; req0_valid = 1'b1;
    txn(0, "t4b");
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 5: reset during EXEC, then during RESP; priority returns to port 0
    req0_a = 3; req0_b = 4; req0_op = 3'b000; req0_valid = 1'b1;
    req1_a = 9; req1_b = 1; req1_op = 3'b001; req1_valid = 1'b1;
    abort(1'b0, "t5 exec");
    req0_valid = 1'b1; req1_valid = 1'b1;
    txn(0, "t5a");
    abort(1'b1, "t5 resp");
    req0_valid = 1'b1; req1_valid = 1'b1;
    txn(0, "t5b");
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 6: undefined op code, followed immediately by another op
    req0_a = 1; req0_b = 1; req0_op = 3'b010; req0_valid = 1'b1;
    txn(0, "t6a");
    req0_valid = 1'b0;
    req1_a = 'hFFFF_FFFF; req1_b = 1; req1_op = 3'b000; req1_valid = 1'b1;
    txn(0, "t6b");
    req1_valid = 1'b0;

    chk("scoreboard empty", 32'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
